pixel_stream_receiver: RTL

- Receiving end of the pixel transfer link. Accepts a byte stream from a host-side source and reassembles 12-bit RGB444 pixels.
- Generates raster row/col coordinates for each pixel and presents them to the masking pipeline (imm-compatible pixel/row/col) behind a valid/ready output register.
- Replaces the ROM-fed transfer path when images arrive at run time; runs on the 50 MHz pipeline clock.

---
 rtl/ima_pkg.sv | 24 ++
 rtl/raster_counter.sv | 53 +++++
 rtl/pixel_stream_receiver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ima_pkg.sv
// Shared definitions for the image pixel path: frame geometry, field widths,
// receiver state encoding and the stream sync nibble.
package ima_pkg;

    localparam int IMG_ROWS = 240;
    localparam int IMG_COLS = 320;
    localparam int ROW_W    = 8;
    localparam int COL_W    = 9;
    localparam int PIX_W    = 12;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } rx_state_e;

    // RGB444 pixel from the red nibble of the high byte and the {g,b} low byte.
    function automatic logic [PIX_W-1:0] make_pixel(input logic [3:0] red, input logic [7:0] lo);
        return {red, lo};
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter with line wrap, frame wrap and a
// last-pixel flag; shared by the transfer and VGA paths.
module raster_counter import ima_pkg::*; #(
    parameter int ROWS = IMG_ROWS,
    parameter int COLS = IMG_COLS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_end;

    assign w_col_end = (r_col == LAST_COL);
    assign o_last    = w_col_end && (r_row == LAST_ROW);
    assign o_row     = r_row;
    assign o_col     = r_col;

    // Position update: clear wins over advance; the last pixel wraps both axes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= {ROW_W{1'b0}};
            r_col <= {COL_W{1'b0}};
        end else if (i_clear) begin
            r_row <= {ROW_W{1'b0}};
            r_col <= {COL_W{1'b0}};
        end else if (i_advance) begin
            if (o_last) begin
                r_row <= {ROW_W{1'b0}};
                r_col <= {COL_W{1'b0}};
            end else if (w_col_end) begin
                r_row <= r_row + ROW_W'(1);
                r_col <= {COL_W{1'b0}};
            end else begin
                r_row <= r_row;
                r_col <= r_col + COL_W'(1);
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

endmodule

// File: rtl/pixel_stream_receiver.sv
// Reassembles RGB444 pixels from a two-byte-per-pixel stream and presents them
// with raster coordinates behind a valid/ready output register.
module pixel_stream_receiver #(
    parameter int IMG_ROWS = ima_pkg::IMG_ROWS,
    parameter int IMG_COLS = ima_pkg::IMG_COLS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sof,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ima_pkg::PIX_W-1:0] pixel_out,
    output logic [ima_pkg::ROW_W-1:0] pix_row,
    output logic [ima_pkg::COL_W-1:0] pix_col,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     sync_err
);
    import ima_pkg::*;

    rx_state_e        r_state;
    logic [3:0]       r_red;
    logic [PIX_W-1:0] r_pixel;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_out_valid;
    logic             r_last_held;
    logic             r_frame_done;
    logic             r_sync_err;

    logic             w_accept;
    logic             w_take;
    logic             w_advance;
    logic [ROW_W-1:0] w_cnt_row;
    logic [COL_W-1:0] w_cnt_col;
    logic             w_cnt_last;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready && !sof;
    assign w_take     = r_out_valid && out_ready;
    assign w_advance  = (r_state == ST_LO) && w_accept;

    assign pixel_out  = r_pixel;
    assign pix_row    = r_row;
    assign pix_col    = r_col;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

    raster_counter #(
        .ROWS (IMG_ROWS),
        .COLS (IMG_COLS)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (sof),
        .i_advance (w_advance),
        .o_row     (w_cnt_row),
        .o_col     (w_cnt_col),
        .o_last    (w_cnt_last)
    );

    // Receive FSM and output register. Later assignments win, so a pixel loaded
    // in the same cycle as an acceptance keeps out_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_red        <= 4'h0;
            r_pixel      <= {PIX_W{1'b0}};
            r_row        <= {ROW_W{1'b0}};
            r_col        <= {COL_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_last_held  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_take) begin
                r_out_valid <= 1'b0;
                if (r_last_held) begin
                    r_frame_done <= 1'b1;
                    r_last_held  <= 1'b0;
                end
            end
            if (sof) begin
                r_state    <= ST_HI;
                r_sync_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_HI: begin
                        if (w_accept) begin
                            if (in_data[7:4] == SYNC_NIBBLE) begin
                                r_red   <= in_data[3:0];
                                r_state <= ST_LO;
                            end else begin
                                r_sync_err <= 1'b1;
                            end
                        end
                    end
                    ST_LO: begin
                        if (w_accept) begin
                            r_pixel     <= make_pixel(r_red, in_data);
                            r_row       <= w_cnt_row;
                            r_col       <= w_cnt_col;
                            r_out_valid <= 1'b1;
                            r_last_held <= w_cnt_last;
                            r_state     <= w_cnt_last ? ST_IDLE : ST_HI;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
